// File: rtl/regmst_multi_ext.sv
// APB slave that forwards each access to one of EXT_NUM external register ports,
// selected by address window, with per-access ack timeout and a sticky timeout interrupt.
module regmst_multi_ext #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    EXT_NUM    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    WIN_BITS   = 12,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic [EXT_NUM-1:0]            ext_req_vld,
  input  logic [EXT_NUM-1:0]            ext_ack_vld,
  output logic                          ext_wr_en,
  output logic                          ext_rd_en,
  output logic [ADDR_WIDTH-1:0]         ext_addr,
  output logic [DATA_WIDTH-1:0]         ext_wr_data,
  input  logic [EXT_NUM*DATA_WIDTH-1:0] ext_rd_data,
  input  logic                          clear,
  output logic                          interrupt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] WIN_MASK = (ADDR_WIDTH'(1) << WIN_BITS) - ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt_q;
  logic [EXT_NUM-1:0]      port_q;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   win_idx;
  logic                    hit;
  logic [EXT_NUM-1:0]      dec_mask;
  logic                    ack_hit;
  logic                    timed_out;
  logic [DATA_WIDTH-1:0]   rd_sel;

  // Decode and read-data selection work on a one-hot port mask to avoid index width issues.
  always_comb begin
    offset   = PADDR - BASE_ADDR;
    win_idx  = offset >> WIN_BITS;
    hit      = (PADDR >= BASE_ADDR) && (win_idx < ADDR_WIDTH'(EXT_NUM));
    dec_mask = '0;
    for (int unsigned i = 0; i < EXT_NUM; i++) begin
      if (win_idx == ADDR_WIDTH'(i)) dec_mask[i] = 1'b1;
    end
    ack_hit = |(ext_ack_vld & port_q);
    rd_sel  = '0;
    for (int unsigned i = 0; i < EXT_NUM; i++) begin
      if (port_q[i]) rd_sel = ext_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      cnt_q       <= '0;
      port_q      <= '0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      PRDATA      <= '0;
      ext_req_vld <= '0;
      ext_wr_en   <= 1'b0;
      ext_rd_en   <= 1'b0;
      ext_addr    <= '0;
      ext_wr_data <= '0;
      interrupt   <= 1'b0;
    end else begin
      ext_req_vld <= '0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      PRDATA      <= '0;
      if (clear) interrupt <= 1'b0;
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            if (hit) begin
              port_q      <= dec_mask;
              ext_req_vld <= dec_mask;
              ext_addr    <= offset & WIN_MASK;
              ext_wr_en   <= PWRITE;
              ext_rd_en   <= !PWRITE;
              ext_wr_data <= PWDATA;
              cnt_q       <= '0;
              state       <= REQ;
            end else begin
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              state   <= DONE;
            end
          end
        end
        REQ, WAIT: begin
          // Ack is checked first so an ack on the final counted cycle beats the timeout.
          if (ack_hit) begin
            PREADY <= 1'b1;
            PRDATA <= ext_wr_en ? '0 : rd_sel;
            state  <= DONE;
          end else if (timed_out) begin
            PREADY    <= 1'b1;
            PSLVERR   <= 1'b1;
            interrupt <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            state <= WAIT;
          end
        end
        DONE: begin
          port_q      <= '0;
          ext_wr_en   <= 1'b0;
          ext_rd_en   <= 1'b0;
          ext_addr    <= '0;
          ext_wr_data <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
